// File: rtl/i2s_rx_frame_fifo_if.sv
// Frame-side bundle between the I2S receiver / DSP consumer and the stereo frame FIFO.
interface i2s_rx_frame_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  logic                   ws;
  logic [WIDTH-1:0]       left_in;
  logic [WIDTH-1:0]       right_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_left;
  logic [WIDTH-1:0]       out_right;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clear_ovf;

  modport slave (
    input  ws, left_in, right_in, out_ready, clear_ovf,
    output out_valid, out_left, out_right, count, overflow
  );

  modport master (
    output ws, left_in, right_in, out_ready, clear_ovf,
    input  out_valid, out_left, out_right, count, overflow
  );
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// Stereo frame buffer behind the I2S receiver: detects frame end on ws, captures
// left/right one cycle later and queues frames in a first-word-fall-through FIFO.
module i2s_rx_frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic                sclk,
  input logic                rst,
  i2s_rx_frame_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic                 ws_dly_q;
  logic                 pend_q, pend_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];

  logic frame_end, pop, accept, drop;

  always_comb begin
    frame_end = ws_dly_q & ~bus.ws;
    pop       = (count_q != '0) & bus.out_ready;
    // A full FIFO still takes the frame when the head leaves in the same cycle.
    accept    = pend_q & ((count_q != FULL) | pop);
    drop      = pend_q & ~accept;

    pend_d  = ~pend_q & frame_end;
    wptr_d  = accept ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = drop | (ovf_q & ~bus.clear_ovf);
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      ws_dly_q <= 1'b0;
      pend_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ws_dly_q <= bus.ws;
      pend_q   <= pend_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (accept) mem_q[wptr_q] <= {bus.left_in, bus.right_in};
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_left  = mem_q[rptr_q][2*WIDTH-1:WIDTH];
  assign bus.out_right = mem_q[rptr_q][WIDTH-1:0];
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_i2s_rx_frame_fifo.sv
// Self-checking bench for i2s_rx_frame_fifo: vector table, directed corner cases
// and randomized traffic against a queue-based frame model.
module tb_i2s_rx_frame_fifo;
  localparam int W = 16;
  localparam int D = 8;

  logic sclk = 1'b0;
  logic rst  = 1'b0;

  i2s_rx_frame_fifo_if #(.WIDTH(W), .DEPTH(D)) bus();

  i2s_rx_frame_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] mq[$];
  logic [2*W-1:0] popped[$];
  bit             m_pend, m_wsd, m_ovf;
  int             max_cnt;
  int             age;

  typedef struct {
    logic         ws;
    logic         ready;
    logic         exp_valid;
    logic [3:0]   exp_count;
    logic [W-1:0] exp_left;
    logic [W-1:0] exp_right;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_wsd  = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [2*W-1:0] h;
    chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, ".left"}, 32'(bus.out_left), 32'(h[2*W-1:W]));
      chk({tag, ".right"}, 32'(bus.out_right), 32'(h[W-1:0]));
    end
  endtask

  // Advance one clock: apply the frame rules to the queue, then compare after the edge.
  task automatic step(input bit do_check);
    bit pop, drop;
    logic [2*W-1:0] h;
    pop  = (mq.size() != 0) && bus.out_ready;
    drop = 1'b0;
    if (pop) begin
      h = mq.pop_front();
      popped.push_back(h);
    end
    if (m_pend) begin
      if (mq.size() < D) mq.push_back({bus.left_in, bus.right_in});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (bus.clear_ovf) m_ovf = 1'b0;
    m_pend = !m_pend && m_wsd && !bus.ws;
    m_wsd  = bus.ws;
    @(posedge sclk);
    #1;
    if (mq.size() > max_cnt) max_cnt = mq.size();
    if (do_check) check_model("model");
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input bit ready_on_push, input bit clr);
    bus.left_in   = l;
    bus.right_in  = r;
    bus.clear_ovf = clr;
    bus.ws = 1'b1; step(1); step(1);
    bus.ws = 1'b0; step(1);
    bus.out_ready = ready_on_push; step(1);
    bus.out_ready = 1'b0;
    bus.clear_ovf = 1'b0;
  endtask

  task automatic wrap_step();
    if (bus.out_valid) age++;
    else age = 0;
    bus.out_ready = (age >= 3);
    step(1);
    if (bus.out_ready) age = 0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0]   v;
    logic [2*W-1:0] e;

    //            ws    rdy   valid cnt    left      right
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd1, 16'hdead, 16'hbeef};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd1, 16'hdead, 16'hbeef};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};

    bus.ws = 1'b0; bus.left_in = '0; bus.right_in = '0;
    bus.out_ready = 1'b0; bus.clear_ovf = 1'b0;
    max_cnt = 0; age = 0;

    // Reset held with random inputs
    repeat (6) begin
      bus.ws        = 1'($urandom);
      bus.left_in   = W'($urandom);
      bus.right_in  = W'($urandom);
      bus.out_ready = 1'($urandom);
      bus.clear_ovf = 1'($urandom);
      @(posedge sclk);
      #1;
    end
    chk("rst.count", 32'(bus.count), 32'd0);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    chk("rst.left", 32'(bus.out_left), 32'd0);
    chk("rst.right", 32'(bus.out_right), 32'd0);
    bus.ws = 1'b0; bus.left_in = '0; bus.right_in = '0;
    bus.out_ready = 1'b0; bus.clear_ovf = 1'b0;
    @(negedge sclk);
    rst = 1'b1;
    model_reset();
    @(posedge sclk);
    #1;

    // Single frame, cycle by cycle from the vector table
    for (int i = 0; i < 8; i++) begin
      bus.ws        = tbl[i].ws;
      bus.out_ready = tbl[i].ready;
      bus.left_in   = 16'hdead;
      bus.right_in  = 16'hbeef;
      step(0);
      chk($sformatf("tbl%0d.valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.count", i), 32'(bus.count), 32'(tbl[i].exp_count));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d.left", i), 32'(bus.out_left), 32'(tbl[i].exp_left));
        chk($sformatf("tbl%0d.right", i), 32'(bus.out_right), 32'(tbl[i].exp_right));
      end
    end
    bus.out_ready = 1'b0;

    // Fill to DEPTH, then overflow and clear behaviour
    for (int i = 0; i < D; i++) begin
      v = W'(i);
      send_frame(v, ~v, 1'b0, 1'b0);
    end
    chk("full.count", 32'(bus.count), 32'd8);
    chk("full.left", 32'(bus.out_left), 32'h0000);
    chk("full.right", 32'(bus.out_right), 32'hffff);
    v = W'(8);
    send_frame(v, ~v, 1'b0, 1'b0);
    chk("drop.ovf", 32'(bus.overflow), 32'd1);
    chk("drop.count", 32'(bus.count), 32'd8);
    chk("drop.left", 32'(bus.out_left), 32'h0000);
    chk("drop.right", 32'(bus.out_right), 32'hffff);
    bus.clear_ovf = 1'b1; step(1); bus.clear_ovf = 1'b0;
    chk("clr.ovf", 32'(bus.overflow), 32'd0);
    v = W'(9);
    send_frame(v, ~v, 1'b0, 1'b1);
    chk("setwins.ovf", 32'(bus.overflow), 32'd1);

    // Full FIFO with a pop during the push cycle
    bus.clear_ovf = 1'b1; step(1); bus.clear_ovf = 1'b0;
    popped.delete();
    v = W'(8);
    send_frame(v, ~v, 1'b1, 1'b0);
    chk("fullpp.ovf", 32'(bus.overflow), 32'd0);
    chk("fullpp.count", 32'(bus.count), 32'd8);
    bus.out_ready = 1'b1;
    repeat (D) step(1);
    bus.out_ready = 1'b0;
    chk("fullpp.npop", 32'(popped.size()), 32'd9);
    for (int k = 0; k < 9 && k < popped.size(); k++) begin
      v = W'(k);
      e = {v, ~v};
      chk($sformatf("fullpp.pop%0d", k), popped[k], e);
    end
    chk("fullpp.empty", 32'(bus.count), 32'd0);

    // Wrap-around: 20 frames, each head popped after 3 cycles
    popped.delete();
    max_cnt = 0; age = 0;
    for (int f = 0; f < 20; f++) begin
      bus.left_in  = W'(16'h0100 + f);
      bus.right_in = W'(16'h0200 + f);
      for (int s = 0; s < 4; s++) begin
        bus.ws = (s < 2);
        wrap_step();
      end
    end
    bus.ws = 1'b0;
    repeat (10) wrap_step();
    chk("wrap.npop", 32'(popped.size()), 32'd20);
    for (int k = 0; k < 20 && k < popped.size(); k++) begin
      e = {W'(16'h0100 + k), W'(16'h0200 + k)};
      chk($sformatf("wrap.pop%0d", k), popped[k], e);
    end
    chk("wrap.maxcnt_le2", 32'(max_cnt <= 2), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) bus.ws = ~bus.ws;
      bus.left_in   = W'($urandom);
      bus.right_in  = W'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      bus.clear_ovf = ($urandom_range(0, 15) == 0);
      step(1);
    end
    bus.out_ready = 1'b0;
    bus.clear_ovf = 1'b0;

    // Mid-operation reset with three frames stored and a push pending
    bus.out_ready = 1'b1;
    bus.ws = 1'b0;
    repeat (12) step(1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = W'(16'h00a0 + i);
      send_frame(v, ~v, 1'b0, 1'b0);
    end
    bus.left_in = 16'h1234; bus.right_in = 16'h5678;
    bus.ws = 1'b1; step(1); step(1);
    bus.ws = 1'b0; step(1);
    chk("midrst.pre_count", 32'(bus.count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("midrst.count", 32'(bus.count), 32'd0);
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.ovf", 32'(bus.overflow), 32'd0);
    chk("midrst.left", 32'(bus.out_left), 32'd0);
    chk("midrst.right", 32'(bus.out_right), 32'd0);
    #1 rst = 1'b1;
    model_reset();
    repeat (4) step(1);
    chk("midrst.nophantom", 32'(bus.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
